rcosc_clk_div_bank: RTL

- Parametrised successor to the on-chip RC-oscillator clock source wrapper.
- Runs on the globally buffered oscillator clock and holds off all outputs until a programmable startup interval has elapsed.
- Generates NUM_CH independently programmable divided clocks, each with a matching one-cycle clock-enable strobe.
- Divide ratios change glitch-free, at period boundaries only; downstream fabric logic uses the strobes as slow-rate enables.

---
 rtl/rcosc_clk_div_bank.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rcosc_clk_div_bank.sv
// Oscillator clock-source wrapper: startup hold-off plus a bank of independently
// programmable clock dividers, each with a one-cycle enable strobe per divided period.
module rcosc_clk_div_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DIV_W          = 8,
    parameter int unsigned STARTUP_CYCLES = 256,
    parameter int unsigned DEFAULT_DIV    = 2,
    localparam int unsigned SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_LOAD,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic [DIV_W-1:0]  DIV_VALUE,
    output logic              OSC_READY,
    output logic [NUM_CH-1:0] DIV_CLK_OUT,
    output logic [NUM_CH-1:0] CLK_EN_OUT,
    output logic              LOAD_ERR
);

    localparam int unsigned ST_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(STARTUP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEFAULT_DIV);

    typedef enum logic {
        IDLE,
        RUN
    } ch_state_t;

    logic [ST_W-1:0]   st_cnt;
    logic              value_ok;
    logic              sel_ok;
    logic [NUM_CH-1:0] load_hit;

    // Startup hold-off: saturating counter, ready latches until reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_cnt    <= '0;
            OSC_READY <= 1'b0;
        end else if (st_cnt == ST_LAST) begin
            OSC_READY <= 1'b1;
        end else begin
            st_cnt <= st_cnt + ST_W'(1);
        end
    end

    // Load decode; selector range is checked by matching against real channels
    always_comb begin
        value_ok = (DIV_VALUE >= DIV_W'(2));
        sel_ok   = 1'b0;
        load_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (DIV_SEL == SEL_W'(i)) begin
                sel_ok      = 1'b1;
                load_hit[i] = DIV_LOAD & value_ok;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LOAD_ERR <= 1'b0;
        end else begin
            LOAD_ERR <= DIV_LOAD & ~(value_ok & sel_ok);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t        state;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] active;
        logic [DIV_W-1:0] pending;
        logic             pend_valid;
        logic             div_clk;
        logic             clk_en;
        logic             running;
        logic             tc;
        logic             upd_valid;
        logic [DIV_W-1:0] upd_ratio;

        // The start cycle counts as cnt = 0 of the first period
        always_comb begin
            running   = (state == RUN) || (OSC_READY && CH_EN[g]);
            tc        = running && (cnt == active - DIV_W'(1));
            upd_valid = load_hit[g] || pend_valid;
            upd_ratio = load_hit[g] ? DIV_VALUE : pending;
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state      <= IDLE;
                cnt        <= '0;
                active     <= DEF_RATIO;
                pending    <= DEF_RATIO;
                pend_valid <= 1'b0;
                div_clk    <= 1'b0;
                clk_en     <= 1'b0;
            end else begin
                div_clk <= running && (cnt < active - (active >> 1));
                clk_en  <= tc;

                // New ratios only take effect between periods, so no runt cycles
                if (load_hit[g]) begin
                    pending <= DIV_VALUE;
                end
                if (upd_valid && ((state == IDLE) || tc)) begin
                    active     <= upd_ratio;
                    pend_valid <= 1'b0;
                end else if (load_hit[g]) begin
                    pend_valid <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (running) begin
                            state <= RUN;
                            cnt   <= DIV_W'(1);
                        end
                    end
                    RUN: begin
                        if (tc) begin
                            cnt <= '0;
                            if (!CH_EN[g]) begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign DIV_CLK_OUT[g] = div_clk;
        assign CLK_EN_OUT[g]  = clk_en;
    end

endmodule
